top_if: RTL and testbench
=========================

TOP_IF -- requirements
Module: top_if

Interface
REQ-001 Parameter LENGTH_INSTRUCTION, default 32, instruction word width.
REQ-002 Parameter CANT_BITS_ADDR, default 11, PC / instruction-memory word-address width; memory depth 2**CANT_BITS_ADDR.
REQ-003 Parameter HALT_INSTRUCTION, default 32'hFFFFFFFF, halt opcode.
REQ-004 i_clock  in  1  single clock; all state updates on rising edge.
REQ-005 i_soft_reset  in  1  reset, asynchronous, active-low.
REQ-006 i_start  in  1  one-cycle pulse from debug unit, LOAD -> RUN.
REQ-007 i_enable_pipeline  in  1  global advance enable (continuous or single-step).
REQ-008 i_bit_burbuja_hazard  in  1  load-use stall from hazard unit.
REQ-009 i_branch_control  in  1  taken branch/jump resolved in ID.
REQ-010 i_branch_dir  in  CANT_BITS_ADDR  branch/jump target word address.
REQ-011 i_write_mem  in  1  program-load write strobe.
REQ-012 i_addr_mem  in  CANT_BITS_ADDR  program-load word address.
REQ-013 i_data_mem  in  LENGTH_INSTRUCTION  program-load data.
REQ-014 o_instruction  out  LENGTH_INSTRUCTION  IF/ID latched instruction.
REQ-015 o_out_adder_pc  out  CANT_BITS_ADDR  IF/ID latched PC+1 of o_instruction.
REQ-016 o_pc  out  CANT_BITS_ADDR  current PC, debug visibility.
REQ-017 o_halted  out  1  high while in HALTED state.
REQ-018 o_state  out  2  FSM state: 00 LOAD, 01 RUN, 10 HALTED.

Function
REQ-019 FSM states LOAD, RUN, HALTED; LOAD -> RUN on i_start; RUN -> HALTED on halt capture (REQ-026); HALTED exits only by reset; code 11 unreachable, decoded as LOAD.
REQ-020 In LOAD, i_write_mem writes mem[i_addr_mem] <= i_data_mem at the clock edge; PC, o_instruction and o_out_adder_pc hold; i_enable_pipeline ignored.
REQ-021 In RUN and HALTED, i_write_mem is ignored; memory contents are unchanged.
REQ-022 Instruction memory read is combinational: fetch word = mem[PC], zero-latency.
REQ-023 RUN, per edge, first matching rule: ~i_enable_pipeline -> hold all; i_bit_burbuja_hazard -> hold PC and IF/ID latch; i_branch_control -> PC <= i_branch_dir, IF/ID per REQ-025; else PC <= PC+1, o_instruction <= mem[PC], o_out_adder_pc <= PC+1.
REQ-024 PC+1 computed modulo 2**CANT_BITS_ADDR; PC all-ones wraps to 0 with no error flag.
REQ-025 On taken branch, o_out_adder_pc <= PC+1; o_instruction loads per Configuration REQ-032/REQ-033.
REQ-026 Halt capture: fetch word equals HALT_INSTRUCTION on an advancing RUN edge (not held by REQ-023) and not flushed -> word latched into IF/ID, PC holds its value, state -> HALTED.
REQ-027 HALTED: PC, o_instruction, o_out_adder_pc hold regardless of every input.
REQ-028 Bubble simultaneous with branch: bubble wins; branch stays asserted by ID and is taken on the next advancing edge.

Reset
REQ-029 Reset assertion asynchronously forces PC = 0, o_instruction = 0, o_out_adder_pc = 0, state LOAD, o_halted = 0, at any time including mid-RUN or mid-write.
REQ-030 Memory contents are not cleared by reset; a write coinciding with reset assertion is discarded.
REQ-031 Reset release is synchronous to i_clock; first state change is on the following rising edge.

Configuration
REQ-032 Macro IF_BRANCH_FLUSH_EN defined: on taken branch o_instruction <= 32'h0 (NOP, squashes wrong-path fetch); a HALT_INSTRUCTION fetch in that cycle is squashed and not captured.
REQ-033 IF_BRANCH_FLUSH_EN undefined: on taken branch o_instruction <= mem[PC] (branch delay slot executes); a HALT_INSTRUCTION fetch in that cycle is captured, PC holds at the halt address, branch target is dropped.

Verification
REQ-034 Load mem[0..3] = 1,2,3,4, i_start, enable high -> o_instruction 1,2,3,4 on successive edges, o_out_adder_pc 1,2,3,4.
REQ-035 Bubble held 2 cycles at PC=2 -> PC stays 2, o_instruction holds mem[1] for 2 edges, then resumes with mem[2].
REQ-036 Branch to 0x10 at PC=5 -> next PC 0x10; o_instruction = 0 with IF_BRANCH_FLUSH_EN, mem[5] without; o_out_adder_pc = 6.
REQ-037 mem[3] = 32'hFFFFFFFF -> after capture o_halted = 1, o_state = 10, PC = 3, stable over 10 further cycles with enable, branch and bubble toggling.
REQ-038 PC = 11'h7FF advancing -> PC = 0; reset mid-RUN -> all outputs 0, state LOAD immediately without a clock edge, memory intact.

Source files
------------

// File: rtl/top_if.sv
// Instruction-fetch stage: program-load memory, PC, IF/ID latch and LOAD/RUN/HALTED control.
// Optional feature macro: IF_BRANCH_FLUSH_EN (squash the wrong-path fetch on a taken branch).
module top_if #(
   parameter int unsigned LENGTH_INSTRUCTION = 32,
   parameter int unsigned CANT_BITS_ADDR     = 11,
   parameter logic [LENGTH_INSTRUCTION-1:0] HALT_INSTRUCTION = 32'hFFFFFFFF
) (
   input  logic                          i_clock,
   input  logic                          i_soft_reset,
   input  logic                          i_start,
   input  logic                          i_enable_pipeline,
   input  logic                          i_bit_burbuja_hazard,
   input  logic                          i_branch_control,
   input  logic [CANT_BITS_ADDR-1:0]     i_branch_dir,
   input  logic                          i_write_mem,
   input  logic [CANT_BITS_ADDR-1:0]     i_addr_mem,
   input  logic [LENGTH_INSTRUCTION-1:0] i_data_mem,
   output logic [LENGTH_INSTRUCTION-1:0] o_instruction,
   output logic [CANT_BITS_ADDR-1:0]     o_out_adder_pc,
   output logic [CANT_BITS_ADDR-1:0]     o_pc,
   output logic                          o_halted,
   output logic [1:0]                    o_state
);

   localparam int unsigned DEPTH = 2 ** CANT_BITS_ADDR;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'b00,
      ST_RUN    = 2'b01,
      ST_HALTED = 2'b10
   } state_t;

   state_t                        state, state_nxt;
   logic [CANT_BITS_ADDR-1:0]     pc, pc_nxt, pc_inc;
   logic [LENGTH_INSTRUCTION-1:0] instr, instr_nxt, fetch_c;
   logic [CANT_BITS_ADDR-1:0]     adder, adder_nxt;
   logic                          mem_we_c;
   logic                          advance_c;
   logic                          halt_capture_c;

   logic [LENGTH_INSTRUCTION-1:0] mem [DEPTH];

   // Zero-latency fetch and wrapping PC increment
   assign fetch_c   = mem[pc];
   assign pc_inc    = pc + CANT_BITS_ADDR'(1);
   assign advance_c = i_enable_pipeline & ~i_bit_burbuja_hazard;

`ifdef IF_BRANCH_FLUSH_EN
   // A halt word in the shadow of a taken branch is squashed, never captured
   assign halt_capture_c = (state == ST_RUN) & advance_c & ~i_branch_control &
                           (fetch_c == HALT_INSTRUCTION);
`else
   // A halt word in the delay slot is captured and the branch target is dropped
   assign halt_capture_c = (state == ST_RUN) & advance_c &
                           (fetch_c == HALT_INSTRUCTION);
`endif

   // State register
   always_ff @(posedge i_clock or negedge i_soft_reset) begin
      if (!i_soft_reset) state <= ST_LOAD;
      else               state <= state_nxt;
   end

   // Next-state: LOAD -> RUN on start, RUN -> HALTED on halt capture, HALTED sticky
   always_comb begin
      state_nxt = state;
      case (state)
         ST_LOAD:   if (i_start) state_nxt = ST_RUN;
         ST_RUN:    if (halt_capture_c) state_nxt = ST_HALTED;
         ST_HALTED: state_nxt = ST_HALTED;
         default:   state_nxt = i_start ? ST_RUN : ST_LOAD;
      endcase
   end

   // Datapath control: memory write in LOAD, PC / IF/ID update rules in RUN
   always_comb begin
      pc_nxt    = pc;
      instr_nxt = instr;
      adder_nxt = adder;
      mem_we_c  = 1'b0;
      case (state)
         ST_RUN: begin
            if (!i_enable_pipeline) begin
               pc_nxt = pc;
            end else if (i_bit_burbuja_hazard) begin
               pc_nxt = pc;
            end else if (halt_capture_c) begin
               instr_nxt = fetch_c;
               adder_nxt = pc_inc;
            end else if (i_branch_control) begin
               pc_nxt    = i_branch_dir;
               adder_nxt = pc_inc;
`ifdef IF_BRANCH_FLUSH_EN
               instr_nxt = '0;
`else
               instr_nxt = fetch_c;
`endif
            end else begin
               pc_nxt    = pc_inc;
               instr_nxt = fetch_c;
               adder_nxt = pc_inc;
            end
         end
         ST_HALTED: pc_nxt = pc;
         default:   mem_we_c = i_write_mem & i_soft_reset;
      endcase
   end

   // PC and IF/ID latch
   always_ff @(posedge i_clock or negedge i_soft_reset) begin
      if (!i_soft_reset) begin
         pc    <= '0;
         instr <= '0;
         adder <= '0;
      end else begin
         pc    <= pc_nxt;
         instr <= instr_nxt;
         adder <= adder_nxt;
      end
   end

   // Instruction memory; contents survive reset
   always_ff @(posedge i_clock) begin
      if (mem_we_c) mem[i_addr_mem] <= i_data_mem;
   end

   assign o_instruction  = instr;
   assign o_out_adder_pc = adder;
   assign o_pc           = pc;
   assign o_state        = state;
   assign o_halted       = (state == ST_HALTED);

endmodule

// File: tb/tb_top_if.sv
// Directed bench for top_if: load, run, bubble, branch, wrap, halt and async reset.
module tb_top_if;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_start, i_enable_pipeline, i_bit_burbuja_hazard, i_branch_control;
   logic [10:0] i_branch_dir, i_addr_mem;
   logic        i_write_mem;
   logic [31:0] i_data_mem;
   logic [31:0] o_instruction;
   logic [10:0] o_out_adder_pc, o_pc;
   logic        o_halted;
   logic [1:0]  o_state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   top_if dut (
      .i_clock              (clk),
      .i_soft_reset         (rst_n),
      .i_start              (i_start),
      .i_enable_pipeline    (i_enable_pipeline),
      .i_bit_burbuja_hazard (i_bit_burbuja_hazard),
      .i_branch_control     (i_branch_control),
      .i_branch_dir         (i_branch_dir),
      .i_write_mem          (i_write_mem),
      .i_addr_mem           (i_addr_mem),
      .i_data_mem           (i_data_mem),
      .o_instruction        (o_instruction),
      .o_out_adder_pc       (o_out_adder_pc),
      .o_pc                 (o_pc),
      .o_halted             (o_halted),
      .o_state              (o_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [10:0] a, input logic [31:0] d);
      i_write_mem = 1'b1;
      i_addr_mem  = a;
      i_data_mem  = d;
      step();
      i_write_mem = 1'b0;
   endtask

   task automatic start();
      i_start = 1'b1;
      step();
      i_start = 1'b0;
   endtask

   task automatic chk_fetch(input string tag, input logic [31:0] ins,
                            input logic [10:0] add, input logic [10:0] pc);
      check({tag, "_instr"}, o_instruction, ins);
      check({tag, "_adder"}, 32'(o_out_adder_pc), 32'(add));
      check({tag, "_pc"}, 32'(o_pc), 32'(pc));
   endtask

   initial begin
      logic [31:0] exp_br1, exp_br2;
`ifdef IF_BRANCH_FLUSH_EN
      exp_br1 = 32'h0;
      exp_br2 = 32'h0;
`else
      exp_br1 = 32'h6;
      exp_br2 = 32'h100;
`endif
      rst_n = 1'b0;
      i_start = 1'b0; i_enable_pipeline = 1'b1; i_bit_burbuja_hazard = 1'b0;
      i_branch_control = 1'b0; i_branch_dir = '0;
      i_write_mem = 1'b0; i_addr_mem = '0; i_data_mem = '0;
      step();
      step();
      chk_fetch("rst", 32'h0, 11'h0, 11'h0);
      check("rst_state", 32'(o_state), 32'h0);
      check("rst_halted", 32'(o_halted), 32'h0);
      rst_n = 1'b1;

      // Phase A: program load with enable high (must be ignored in LOAD)
      for (int i = 0; i < 8; i++) load(11'(i), 32'(i + 1));
      load(11'h010, 32'h100);
      load(11'h011, 32'h101);
      load(11'h7FF, 32'h7FF5);
      chk_fetch("load_hold", 32'h0, 11'h0, 11'h0);
      check("load_state", 32'(o_state), 32'h0);
      start();
      check("start_state", 32'(o_state), 32'h1);
      check("start_pc", 32'(o_pc), 32'h0);

      step(); chk_fetch("seq1", 32'h1, 11'h1, 11'h1);
      step(); chk_fetch("seq2", 32'h2, 11'h2, 11'h2);

      i_bit_burbuja_hazard = 1'b1;
      step(); chk_fetch("bub1", 32'h2, 11'h2, 11'h2);
      step(); chk_fetch("bub2", 32'h2, 11'h2, 11'h2);
      i_bit_burbuja_hazard = 1'b0;
      step(); chk_fetch("seq3", 32'h3, 11'h3, 11'h3);
      step(); chk_fetch("seq4", 32'h4, 11'h4, 11'h4);
      step(); chk_fetch("seq5", 32'h5, 11'h5, 11'h5);

      i_branch_control = 1'b1; i_branch_dir = 11'h010;
      step(); chk_fetch("br", exp_br1, 11'h6, 11'h010);

      // Bubble beats a simultaneous branch; branch taken on the next advancing edge
      i_bit_burbuja_hazard = 1'b1; i_branch_dir = 11'h7FF;
      step(); chk_fetch("br_bub", exp_br1, 11'h6, 11'h010);
      i_bit_burbuja_hazard = 1'b0;
      step(); chk_fetch("br_late", exp_br2, 11'h011, 11'h7FF);
      i_branch_control = 1'b0;
      step(); chk_fetch("wrap", 32'h7FF5, 11'h0, 11'h0);

      i_enable_pipeline = 1'b0;
      step(); chk_fetch("en_off", 32'h7FF5, 11'h0, 11'h0);
      i_write_mem = 1'b1; i_addr_mem = 11'h1; i_data_mem = 32'hDEAD;
      step();
      i_write_mem = 1'b0; i_enable_pipeline = 1'b1;
      step(); chk_fetch("run_a", 32'h1, 11'h1, 11'h1);
      step(); chk_fetch("run_wr_ign", 32'h2, 11'h2, 11'h2);

      // Asynchronous reset mid-RUN, with a write attempt while reset is held
      #2;
      rst_n = 1'b0;
      #1;
      chk_fetch("async_rst", 32'h0, 11'h0, 11'h0);
      check("async_rst_state", 32'(o_state), 32'h0);
      check("async_rst_halted", 32'(o_halted), 32'h0);
      i_write_mem = 1'b1; i_addr_mem = 11'h2; i_data_mem = 32'hBAD;
      step();
      i_write_mem = 1'b0;
      rst_n = 1'b1;

      // Phase B: halt capture at address 3
      load(11'h3, 32'hFFFFFFFF);
      start();
      step(); chk_fetch("h1", 32'h1, 11'h1, 11'h1);
      step(); chk_fetch("h2", 32'h2, 11'h2, 11'h2);
      step(); chk_fetch("h3_mem_intact", 32'h3, 11'h3, 11'h3);
      step(); chk_fetch("halt", 32'hFFFFFFFF, 11'h4, 11'h3);
      check("halt_flag", 32'(o_halted), 32'h1);
      check("halt_state", 32'(o_state), 32'h2);
      for (int i = 0; i < 10; i++) begin
         i_enable_pipeline    = i[0];
         i_branch_control     = i[1];
         i_bit_burbuja_hazard = i[2];
         i_branch_dir         = 11'h020;
         i_write_mem          = 1'b1;
         i_addr_mem           = 11'h0;
         i_data_mem           = 32'hC0DE;
         i_start              = i[3];
         step();
         check("halted_pc", 32'(o_pc), 32'h3);
         check("halted_instr", o_instruction, 32'hFFFFFFFF);
         check("halted_flag", 32'(o_halted), 32'h1);
      end
      i_enable_pipeline = 1'b1; i_branch_control = 1'b0; i_bit_burbuja_hazard = 1'b0;
      i_write_mem = 1'b0; i_start = 1'b0;

      // Phase C: halt word in the shadow of a taken branch
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      start();
      step(); chk_fetch("c1_mem0", 32'h1, 11'h1, 11'h1);
      step();
      step(); chk_fetch("c3", 32'h3, 11'h3, 11'h3);
      i_branch_control = 1'b1; i_branch_dir = 11'h010;
      step();
`ifdef IF_BRANCH_FLUSH_EN
      chk_fetch("br_halt", 32'h0, 11'h4, 11'h010);
      check("br_halt_state", 32'(o_state), 32'h1);
`else
      chk_fetch("br_halt", 32'hFFFFFFFF, 11'h4, 11'h3);
      check("br_halt_state", 32'(o_state), 32'h2);
`endif
      i_branch_control = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
